// File: rtl/Fetch_pkg.sv
// Fetch_pkg: fetch-stage FSM state encoding and the reset instruction.
package Fetch_pkg;
  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    FAULT
  } fetch_state_t;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/PCsource_pkg.sv
// PCsource_pkg: next-PC select encoding shared by the control unit and fetch.
//   NEXT - sequential (pc + 4)
//   JUMP - pc-relative (pc + imm_ext)
//   INDJ - register-indirect (alu_result with bit 0 cleared)
package PCsource_pkg;
  typedef enum logic [1:0] {
    NEXT = 2'b00,
    JUMP = 2'b01,
    INDJ = 2'b10
  } PCsource_t;
endpackage

// File: rtl/instr_fetch_unit_next_pc_gen.sv
// next_pc_gen: combinational next-PC selection for the fetch stage.
//   pc, PCSrc, imm_ext, alu_result -> next_pc, misaligned
//   misaligned flags a target that is not 4-byte aligned.
module next_pc_gen
  import PCsource_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  PCsource_t       PCSrc,
  input  logic [XLEN-1:0] imm_ext,
  input  logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned
);

  // Bit 0 of the indirect target is dropped by definition of the jump.
  logic unused_ok;
  assign unused_ok = alu_result[0];

  always_comb begin
    next_pc = pc + XLEN'(4);
    case (PCSrc)
      JUMP:    next_pc = pc + imm_ext;
      INDJ:    next_pc = {alu_result[XLEN-1:1], 1'b0};
      default: next_pc = pc + XLEN'(4);
    endcase
    misaligned = (next_pc[1:0] != 2'b00);
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: single-outstanding instruction fetch stage.
//   clk, rst_n                        - clock, async active-low reset
//   PCSrc, imm_ext, alu_result        - next-PC controls, sampled on accept only
//   imem_req/addr/gnt/rvalid/rdata    - instruction memory handshake
//   instr, instr_valid, instr_ready   - instruction to decode (valid/ready)
//   pc, pc_plus4                      - address of instr and its link value
//   fetch_fault                       - sticky misaligned-target fault
//   instret                           - retired-instruction counter
module instr_fetch_unit
  import PCsource_pkg::*;
  import Fetch_pkg::*;
#(
  parameter int              XLEN     = 32,  // only 32 is supported
  parameter logic [XLEN-1:0] RESET_PC = '0   // must be 4-byte aligned
) (
  input  logic            clk,
  input  logic            rst_n,
  input  PCsource_t       PCSrc,
  input  logic [XLEN-1:0] imm_ext,
  input  logic [XLEN-1:0] alu_result,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            fetch_fault,
  output logic [XLEN-1:0] instret
);

  fetch_state_t    state, state_next;
  logic [XLEN-1:0] next_pc;
  logic            misaligned;
  logic            accept;

  next_pc_gen #(.XLEN(XLEN)) u_next_pc (
    .pc         (pc),
    .PCSrc      (PCSrc),
    .imm_ext    (imm_ext),
    .alu_result (alu_result),
    .next_pc    (next_pc),
    .misaligned (misaligned)
  );

  assign accept    = (state == HOLD) && instr_ready;
  assign imem_addr = pc;
  assign pc_plus4  = pc + XLEN'(4);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = REQ;
      REQ:     if (imem_gnt)    state_next = WAIT;
      WAIT:    if (imem_rvalid) state_next = HOLD;
      HOLD:    if (instr_ready) state_next = misaligned ? FAULT : REQ;
      FAULT:   state_next = FAULT;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decode from the registered state only, so there is no
  // combinational path from any input to req/valid.
  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state)
      REQ:     imem_req    = 1'b1;
      HOLD:    instr_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath registers. A faulting accept still retires the instruction
  // (instret counts) but leaves pc on the faulting instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      instr       <= NOP_INSTR;
      fetch_fault <= 1'b0;
      instret     <= '0;
    end else begin
      if (state == WAIT && imem_rvalid) instr <= imem_rdata;
      if (accept) begin
        instret <= instret + XLEN'(1);
        if (misaligned) fetch_fault <= 1'b1;
        else            pc          <= next_pc;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  import PCsource_pkg::*;
  import Fetch_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  PCsource_t   PCSrc = NEXT;
  logic [31:0] imm_ext = '0, alu_result = '0;
  logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0;
  logic [31:0] instr, pc, pc_plus4, instret;
  logic        instr_valid, instr_ready = 1'b0, fetch_fault;

  instr_fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .PCSrc(PCSrc), .imm_ext(imm_ext),
    .alu_result(alu_result), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .pc(pc), .pc_plus4(pc_plus4), .fetch_fault(fetch_fault), .instret(instret)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rst_n) assert (!(imem_gnt && imem_rvalid)) else $error("illegal stimulus: gnt with rvalid");

  int checks = 0, failures = 0;
  int last_wait;

  // Reference model: architectural state only.
  logic [31:0] m_pc, m_instret;
  logic        m_fault;

  function automatic logic [31:0] ref_target(PCsource_t s, logic [31:0] p, logic [31:0] imm,
                                             logic [31:0] alu);
    case (s)
      JUMP:    return p + imm;
      INDJ:    return alu - (alu % 2);
      default: return p + 32'd4;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic PCsource_t rand_src();
    return PCsource_t'($urandom_range(0, 2));
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    imem_gnt = 0; imem_rvalid = 0; instr_ready = 0;
    chk("rst_req", imem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_fault", fetch_fault, 0);
    chk("rst_instret", instret, 0);
    chk("rst_pc", pc, RESET_PC);
    chk("rst_instr", instr, NOP_INSTR);
    m_pc = RESET_PC; m_instret = 0; m_fault = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One full transaction: request, grant after gd, data after rd, stall st, accept.
  task automatic fetch_one(input int gd, input int rd, input int st, input logic [31:0] data,
                           input PCsource_t src, input logic [31:0] imm, input logic [31:0] alu,
                           input bit noise, input bit force_ones);
    int n = 0;
    logic [31:0] tgt;
    while (!imem_req && n < 8) begin @(negedge clk); n++; end
    last_wait = n;
    chk("req_seen", imem_req, 1);
    if (!imem_req) return;
    chk("req_addr", imem_addr, m_pc);
    for (int i = 0; i < gd; i++) begin
      imem_rvalid = noise & 1'($urandom_range(0, 1));
      imem_rdata  = $urandom;
      instr_ready = 1'($urandom_range(0, 1));
      PCSrc = rand_src(); imm_ext = $urandom; alu_result = $urandom;
      @(negedge clk);
      chk("req_hold", imem_req, 1);
      chk("addr_stable", imem_addr, m_pc);
      chk("req_no_valid", instr_valid, 0);
    end
    imem_rvalid = 0; imem_gnt = 1;
    @(negedge clk);
    imem_gnt = 0;
    chk("req_drop", imem_req, 0);
    for (int i = 0; i < rd; i++) begin
      @(negedge clk);
      chk("wait_no_valid", instr_valid, 0);
      chk("wait_no_req", imem_req, 0);
    end
    imem_rvalid = 1; imem_rdata = data;
    @(negedge clk);
    imem_rvalid = 0; imem_rdata = $urandom;
    chk("valid", instr_valid, 1);
    chk("instr", instr, data);
    chk("pc", pc, m_pc);
    chk("pc_plus4", pc_plus4, m_pc + 32'd4);
    for (int i = 0; i < st; i++) begin
      instr_ready = 0;
      imem_rvalid = noise & 1'($urandom_range(0, 1));
      imem_rdata  = $urandom;
      PCSrc = rand_src(); imm_ext = $urandom; alu_result = $urandom;
      @(negedge clk);
      chk("stall_instr", instr, data);
      chk("stall_pc", pc, m_pc);
      chk("stall_pc4", pc_plus4, m_pc + 32'd4);
      chk("stall_valid", instr_valid, 1);
      chk("stall_no_req", imem_req, 0);
    end
    imem_rvalid = 0;
    if (force_ones) begin
      force dut.instret = 32'hFFFF_FFFF;
      #1 release dut.instret;
      m_instret = 32'hFFFF_FFFF;
    end
    instr_ready = 1; PCSrc = src; imm_ext = imm; alu_result = alu;
    @(negedge clk);
    instr_ready = 0; PCSrc = rand_src(); imm_ext = $urandom; alu_result = $urandom;
    tgt = ref_target(src, m_pc, imm, alu);
    m_instret = m_instret + 1;
    if (tgt[1:0] != 2'b00) m_fault = 1; else m_pc = tgt;
    chk("instret", instret, m_instret);
    chk("fault", fetch_fault, m_fault);
    chk("acc_no_valid", instr_valid, 0);
    chk("acc_req", imem_req, !m_fault);
    chk("acc_pc", pc, m_pc);
  endtask

  task automatic fault_hold(input logic [31:0] exp_pc);
    for (int i = 0; i < 5; i++) begin
      imem_rvalid = 1'($urandom_range(0, 1));
      instr_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("flt_req", imem_req, 0);
      chk("flt_valid", instr_valid, 0);
      chk("flt_sticky", fetch_fault, 1);
      chk("flt_pc", pc, exp_pc);
    end
    imem_rvalid = 0; instr_ready = 0;
  endtask

  typedef struct {
    int          gd, rd, st;
    logic [31:0] data;
    PCsource_t   src;
    logic [31:0] imm, alu, exp_pc;
    logic        exp_fault;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{0, 0, 0, 32'h0050_0093, NEXT, 32'h0,         32'h0,   32'h0000_0004, 1'b0};
    tbl[1] = '{3, 2, 5, 32'h0010_0113, NEXT, 32'h0,         32'h0,   32'h0000_0008, 1'b0};
    tbl[2] = '{1, 0, 1, 32'h0000_006F, JUMP, 32'h0000_00F8, 32'h0,   32'h0000_0100, 1'b0};
    tbl[3] = '{0, 1, 0, 32'hFF9F_F06F, JUMP, 32'hFFFF_FFF8, 32'h0,   32'h0000_00F8, 1'b0};
    tbl[4] = '{2, 0, 2, 32'h0000_8067, INDJ, 32'h0,         32'h205, 32'h0000_0204, 1'b0};
    tbl[5] = '{0, 0, 0, 32'h1234_5678, JUMP, 32'hFFFF_FDF8, 32'h0,   32'hFFFF_FFFC, 1'b0};
    tbl[6] = '{1, 1, 1, 32'h0000_0013, NEXT, 32'h0,         32'h0,   32'h0000_0000, 1'b0};
    tbl[7] = '{0, 0, 0, 32'h0000_8067, INDJ, 32'h0,         32'h103, 32'h0000_0000, 1'b1};

    // Reset values and first fetch timing, then the vector table
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      fetch_one(tbl[i].gd, tbl[i].rd, tbl[i].st, tbl[i].data, tbl[i].src,
                tbl[i].imm, tbl[i].alu, 1'b0, 1'b0);
      if (i == 0) chk("first_req_cycle", last_wait, 1);
      chk("tbl_pc", pc, tbl[i].exp_pc);
      chk("tbl_fault", fetch_fault, tbl[i].exp_fault);
    end
    chk("tbl_instret", instret, 8);
    fault_hold(32'h0);

    // INDJ to a target with bit 1 set faults and keeps pc
    apply_reset();
    fetch_one(0, 0, 0, 32'h1, JUMP, 32'h100, 32'h0, 1'b0, 1'b0);
    fetch_one(0, 0, 0, 32'h2, INDJ, 32'h0, 32'h207, 1'b0, 1'b0);
    chk("indj_fault", fetch_fault, 1);
    chk("indj_pc", pc, 32'h100);
    fault_hold(32'h100);

    // Misaligned JUMP fault, then reset restarts at RESET_PC
    apply_reset();
    fetch_one(0, 0, 0, 32'h3, JUMP, 32'h10, 32'h0, 1'b0, 1'b0);
    fetch_one(1, 1, 1, 32'h4, JUMP, 32'h6, 32'h0, 1'b0, 1'b0);
    chk("jmp_fault", fetch_fault, 1);
    chk("jmp_pc", pc, 32'h10);
    fault_hold(32'h10);
    apply_reset();
    @(negedge clk);
    chk("restart_req", imem_req, 1);
    chk("restart_addr", imem_addr, RESET_PC);
    chk("restart_fault", fetch_fault, 0);

    // PC wrap and instret wrap
    fetch_one(0, 0, 0, 32'h5, JUMP, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0);
    fetch_one(0, 0, 0, 32'h6, NEXT, 32'h0, 32'h0, 1'b0, 1'b1);
    chk("wrap_pc", imem_addr, 32'h0);
    chk("wrap_fault", fetch_fault, 0);
    chk("wrap_instret", instret, 32'h0);

    // Asynchronous reset between edges in WAIT, then in HOLD
    for (int h = 0; h < 2; h++) begin
      apply_reset();
      fetch_one(0, 0, 0, 32'h7, JUMP, 32'h40, 32'h0, 1'b0, 1'b0);
      while (!imem_req) @(negedge clk);
      imem_gnt = 1;
      @(negedge clk);
      imem_gnt = 0;
      if (h == 1) begin
        imem_rvalid = 1; imem_rdata = 32'h8;
        @(negedge clk);
        imem_rvalid = 0;
        chk("pre_abort_valid", instr_valid, 1);
      end
      #3 rst_n = 1'b0;
      #1;
      chk("abort_req", imem_req, 0);
      chk("abort_valid", instr_valid, 0);
      chk("abort_pc", pc, RESET_PC);
      chk("abort_instret", instret, 0);
      m_pc = RESET_PC; m_instret = 0; m_fault = 0;
      @(negedge clk);
      rst_n = 1'b1;
      fetch_one(3, 0, 0, 32'h9, NEXT, 32'h0, 32'h0, 1'b1, 1'b0);
      chk("abort_req_latency", 32'(last_wait <= 2), 1);
    end

    // Randomized traffic against the model
    apply_reset();
    for (int k = 0; k < 200; k++) begin
      logic [31:0] imm;
      imm = $urandom;
      if ($urandom_range(0, 9) != 0) imm[1:0] = 2'b00;
      fetch_one($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom,
                rand_src(), imm, $urandom, 1'b1, 1'b0);
      if (m_fault) begin
        fault_hold(m_pc);
        apply_reset();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
